// File: rtl/gray_step_monitor.sv
// gray_step_monitor: synchronises an upstream Gray count, decodes it to binary,
// classifies every transition as a legal +/-1 step or an error, tracks a signed
// position and latches a fault after too many consecutive bad transitions.
module gray_step_monitor #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int POS_W       = 16,
  parameter int ERR_LIMIT   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic             step_valid,
  output logic             step_dir,
  output logic             err_pulse,
  output logic [1:0]       err_code,
  output logic [7:0]       err_count,
  output logic [POS_W-1:0] position,
  output logic             locked,
  output logic             fault
);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, FAULT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] g_prev_q, g_prev_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [3:0]       consec_q, consec_d;
  logic             sv_q, sv_d;
  logic             sd_q, sd_d;
  logic             ep_q, ep_d;
  logic [1:0]       ec_q, ec_d;

  logic [WIDTH-1:0] g_cur;
  logic [WIDTH-1:0] b_cur;
  logic [WIDTH-1:0] b_prev;
  logic [WIDTH-1:0] diff;
  logic             multi_bit;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign g_cur     = sync_q[SYNC_STAGES-1];
  assign b_cur     = gray2bin(g_cur);
  assign b_prev    = gray2bin(g_prev_q);
  assign diff      = g_cur ^ g_prev_q;
  assign multi_bit = (diff & (diff - WIDTH'(1))) != '0;

  // Synchroniser chain; keeps running in every state so the word is fresh on re-enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Next-state and next-output logic: classify the latest transition while locked.
  always_comb begin
    state_d   = state_q;
    g_prev_d  = g_prev_q;
    bin_d     = bin_q;
    pos_d     = pos_q;
    err_cnt_d = err_cnt_q;
    consec_d  = consec_q;
    sv_d      = 1'b0;
    sd_d      = sd_q;
    ep_d      = 1'b0;
    ec_d      = 2'b00;
    case (state_q)
      IDLE: begin
        if (enable) state_d = ACQUIRE;
      end
      ACQUIRE: begin
        if (!enable) begin
          state_d  = IDLE;
          consec_d = '0;
        end else begin
          g_prev_d = g_cur;
          bin_d    = b_cur;
          state_d  = LOCKED;
        end
      end
      LOCKED: begin
        if (!enable) begin
          state_d  = IDLE;
          consec_d = '0;
        end else if (diff != '0) begin
          g_prev_d = g_cur;
          bin_d    = b_cur;
          if (b_cur == b_prev + WIDTH'(1)) begin
            sv_d     = 1'b1;
            sd_d     = 1'b1;
            pos_d    = pos_q + POS_W'(1);
            consec_d = '0;
          end else if (b_cur == b_prev - WIDTH'(1)) begin
            sv_d     = 1'b1;
            sd_d     = 1'b0;
            pos_d    = pos_q - POS_W'(1);
            consec_d = '0;
          end else begin
            ep_d     = 1'b1;
            ec_d     = multi_bit ? 2'b01 : 2'b10;
            consec_d = consec_q + 4'd1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            if (consec_d == 4'(ERR_LIMIT)) state_d = FAULT;
          end
        end
      end
      FAULT: begin
        if (!enable) begin
          state_d  = IDLE;
          consec_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      g_prev_q  <= '0;
      bin_q     <= '0;
      pos_q     <= '0;
      err_cnt_q <= '0;
      consec_q  <= '0;
      sv_q      <= 1'b0;
      sd_q      <= 1'b0;
      ep_q      <= 1'b0;
      ec_q      <= 2'b00;
    end else begin
      state_q   <= state_d;
      g_prev_q  <= g_prev_d;
      bin_q     <= bin_d;
      pos_q     <= pos_d;
      err_cnt_q <= err_cnt_d;
      consec_q  <= consec_d;
      sv_q      <= sv_d;
      sd_q      <= sd_d;
      ep_q      <= ep_d;
      ec_q      <= ec_d;
    end
  end

  assign bin_out    = bin_q;
  assign step_valid = sv_q;
  assign step_dir   = sd_q;
  assign err_pulse  = ep_q;
  assign err_code   = ec_q;
  assign err_count  = err_cnt_q;
  assign position   = pos_q;
  assign locked     = (state_q == LOCKED);
  assign fault      = (state_q == FAULT);

endmodule

// File: tb/tb_gray_step_monitor.sv
// Testbench for gray_step_monitor: a behavioural model tracks the expected
// outputs from the input history, plus directed scenarios with literal checks.
module tb_gray_step_monitor;

  localparam int SYNC  = 2;
  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  gray_in;
  logic [3:0]  bin_out;
  logic        step_valid;
  logic        step_dir;
  logic        err_pulse;
  logic [1:0]  err_code;
  logic [7:0]  err_count;
  logic [15:0] position;
  logic        locked;
  logic        fault;

  int total = 0;
  int bad = 0;
  bit checkOn = 1'b0;

  int upCnt, dnCnt, errPulses, lastCode;

  int mPipe [SYNC];
  int mPrev, mBin, mErr, mRun, enAge;
  bit tripped;
  logic [15:0] mPos;
  bit mSv, mSd, mEp;
  int mEc;

  gray_step_monitor dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .gray_in   (gray_in),
    .bin_out   (bin_out),
    .step_valid(step_valid),
    .step_dir  (step_dir),
    .err_pulse (err_pulse),
    .err_code  (err_code),
    .err_count (err_count),
    .position  (position),
    .locked    (locked),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  // Gray to binary as a cascade of shifted XORs of the whole word.
  function automatic int g2b(input int g);
    return (g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3)) & 15;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] g, input logic en, input int n);
    gray_in = g;
    enable  = en;
    repeat (n) @(negedge clk);
  endtask

  task automatic restart(input logic [3:0] g);
    reset   = 1'b1;
    enable  = 1'b0;
    gray_in = g;
    repeat (2) @(negedge clk);
    upCnt = 0; dnCnt = 0; errPulses = 0; lastCode = 0;
    reset  = 1'b0;
    enable = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Model: enAge counts consecutive enabled edges (0 waits, 1 captures, 2+ compares).
  always @(posedge clk) begin
    int gc, d;
    gc = mPipe[SYNC-1];
    if (reset) begin
      for (int i = 0; i < SYNC; i++) mPipe[i] = 0;
      mPrev = 0; mBin = 0; mErr = 0; mRun = 0; enAge = 0; tripped = 0;
      mPos = '0; mSv = 0; mSd = 0; mEp = 0; mEc = 0;
    end else begin
      mSv = 0; mEp = 0; mEc = 0;
      if (!enable) begin
        enAge = 0; tripped = 0; mRun = 0;
      end else begin
        if (enAge == 1) begin
          mPrev = gc; mBin = g2b(gc);
        end else if (enAge >= 2 && !tripped && gc != mPrev) begin
          d = (g2b(gc) - g2b(mPrev)) & 15;
          if (d == 1) begin
            mSv = 1; mSd = 1; mPos = mPos + 16'd1; mRun = 0;
          end else if (d == 15) begin
            mSv = 1; mSd = 0; mPos = mPos - 16'd1; mRun = 0;
          end else begin
            mEp = 1;
            mEc = ($countones(4'(gc ^ mPrev)) > 1) ? 1 : 2;
            if (mErr < 255) mErr++;
            mRun++;
            if (mRun == LIMIT) tripped = 1;
          end
          mPrev = gc; mBin = g2b(gc);
        end
        if (enAge < 2) enAge++;
      end
      for (int i = SYNC - 1; i > 0; i--) mPipe[i] = mPipe[i-1];
      mPipe[0] = int'(gray_in);
    end
  end

  // Every-cycle comparison against the model, plus pulse bookkeeping.
  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("bin_out",    int'(bin_out),    mBin);
      checkOutput("step_valid", int'(step_valid), int'(mSv));
      checkOutput("step_dir",   int'(step_dir),   int'(mSd));
      checkOutput("err_pulse",  int'(err_pulse),  int'(mEp));
      checkOutput("err_code",   int'(err_code),   mEc);
      checkOutput("err_count",  int'(err_count),  mErr);
      checkOutput("position",   int'(position),   int'(mPos));
      checkOutput("locked",     int'(locked),     int'(enAge >= 2 && !tripped));
      checkOutput("fault",      int'(fault),      int'(tripped));
      if (step_valid) begin
        if (step_dir) upCnt++;
        else dnCnt++;
      end
      if (err_pulse) begin
        errPulses++;
        lastCode = int'(err_code);
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; gray_in = 4'b0000;
    upCnt = 0; dnCnt = 0; errPulses = 0; lastCode = 0;
    repeat (2) @(negedge clk);
    checkOn = 1'b1;

    // Counting up through five Gray codes.
    restart(4'b0000);
    applyStimulus(4'b0001, 1'b1, 4);
    applyStimulus(4'b0011, 1'b1, 4);
    applyStimulus(4'b0010, 1'b1, 4);
    applyStimulus(4'b0110, 1'b1, 4);
    checkOutput("up_bin",    int'(bin_out),   4);
    checkOutput("up_pos",    int'(position),  4);
    checkOutput("up_steps",  upCnt,           4);
    checkOutput("up_errs",   int'(err_count), 0);
    checkOutput("up_locked", int'(locked),    1);

    // Wrap downwards from 0 to 15.
    restart(4'b0000);
    applyStimulus(4'b1000, 1'b1, 3);
    checkOutput("dn_pulse",  int'(step_valid), 1);
    checkOutput("dn_dir",    int'(step_dir),   0);
    applyStimulus(4'b1000, 1'b1, 1);
    checkOutput("dn_bin",    int'(bin_out),    15);
    checkOutput("dn_pos",    int'(position),   16'hFFFF);
    checkOutput("dn_steps",  dnCnt,            1);

    // Multi-bit error then a legal step from the resynced value.
    restart(4'b0000);
    applyStimulus(4'b0011, 1'b1, 4);
    checkOutput("mb_code",   lastCode,         1);
    checkOutput("mb_bin",    int'(bin_out),    2);
    checkOutput("mb_pos",    int'(position),   0);
    checkOutput("mb_errs",   int'(err_count),  1);
    applyStimulus(4'b0010, 1'b1, 4);
    checkOutput("mb_up_bin", int'(bin_out),    3);
    checkOutput("mb_up_pos", int'(position),   1);

    // Three consecutive errors trip the fault; recovery via enable toggle.
    restart(4'b0000);
    applyStimulus(4'b0010, 1'b1, 4);
    checkOutput("sb_code",   lastCode,         2);
    applyStimulus(4'b0101, 1'b1, 4);
    applyStimulus(4'b1100, 1'b1, 3);
    checkOutput("f_pulse",   int'(err_pulse),  1);
    checkOutput("f_fault",   int'(fault),      1);
    checkOutput("f_locked",  int'(locked),     0);
    applyStimulus(4'b1100, 1'b1, 1);
    checkOutput("f_errs",    int'(err_count),  3);
    applyStimulus(4'b1101, 1'b1, 4);
    checkOutput("f_quiet",   errPulses + upCnt + dnCnt, 3);
    applyStimulus(4'b1101, 1'b0, 2);
    checkOutput("f_cleared", int'(fault),      0);
    applyStimulus(4'b1101, 1'b1, 4);
    checkOutput("re_locked", int'(locked),     1);
    checkOutput("re_bin",    int'(bin_out),    9);
    checkOutput("re_quiet",  errPulses + upCnt + dnCnt, 3);

    // Changes while disabled, then re-acquire at 0110.
    applyStimulus(4'b0111, 1'b0, 2);
    applyStimulus(4'b0101, 1'b0, 2);
    applyStimulus(4'b0100, 1'b0, 2);
    applyStimulus(4'b0110, 1'b0, 3);
    checkOutput("dis_quiet", errPulses + upCnt + dnCnt, 3);
    checkOutput("dis_pos",   int'(position),   0);
    applyStimulus(4'b0110, 1'b1, 4);
    checkOutput("dis_bin",   int'(bin_out),    4);
    checkOutput("dis_noev",  errPulses + upCnt + dnCnt, 3);

    // Reach position 5 with two errors, then reset mid-lock.
    restart(4'b0000);
    applyStimulus(4'b0011, 1'b1, 4);
    applyStimulus(4'b0010, 1'b1, 4);
    applyStimulus(4'b0110, 1'b1, 4);
    applyStimulus(4'b0111, 1'b1, 4);
    applyStimulus(4'b0101, 1'b1, 4);
    applyStimulus(4'b0100, 1'b1, 4);
    applyStimulus(4'b1111, 1'b1, 4);
    checkOutput("pre_pos",   int'(position),   5);
    checkOutput("pre_errs",  int'(err_count),  2);
    checkOutput("pre_bin",   int'(bin_out),    10);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_bin",    int'(bin_out),    0);
    checkOutput("rst_pos",    int'(position),   0);
    checkOutput("rst_errs",   int'(err_count),  0);
    checkOutput("rst_locked", int'(locked),     0);
    checkOutput("rst_dir",    int'(step_dir),   0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
